div_iter: RTL and testbench
===========================

# div_iter

Sequential radix-2 restoring divider for 32-bit signed and unsigned operands. It is the inverse-operation companion of the combinational Booth/Wallace multiplier and sits beside it in the execute stage. It accepts one operation through a valid/ready handshake, iterates one quotient bit per cycle, and presents quotient and remainder through a second valid/ready handshake.

## Interface
- No parameters; width is fixed at 32.
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- src1  input  32  dividend.
- src2  input  32  divisor.
- sign  input  1  1 = signed (two's complement), 0 = unsigned.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- quotient  output  32  result quotient.
- remainder  output  32  result remainder.
- abort  input  1  cancels the in-flight operation; present only with DIV_ABORT_EN.

## Operation
- States: IDLE, BUSY, DONE.
- On reset: state = IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, iteration counter = 0.
- **IDLE:** accepts when in_valid && in_ready. Next state depends on the operands:
  - src2 == 0 → DONE, quotient = 0xFFFFFFFF, remainder = src1 (both modes).
  - sign && src1 == 0x80000000 && src2 == 0xFFFFFFFF → DONE, quotient = 0x80000000, remainder = 0.
  - Otherwise → BUSY. Latch the magnitudes of src1 and src2 (abs when sign is set; 0x80000000 maps to unsigned 2^31). Latch neg_q = sign & (src1[31] ^ src2[31]) and neg_r = sign & src1[31]. Clear the 33-bit partial remainder and the counter.
- **BUSY:** each cycle:
  - shift the partial remainder left, taking in the next dividend bit (MSB first);
  - trial-subtract the divisor;
  - if the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - Counter increments 0..31. On the iteration with counter == 31, register the final values into quotient/remainder: negate the quotient if neg_q, negate the remainder if neg_r. Then → DONE.
- Signed semantics: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- **DONE:** out_valid = 1. quotient and remainder stay stable while out_ready = 0. When out_ready = 1 → IDLE on the next edge.
- There is no same-cycle result-return plus new acceptance; in_ready is low in DONE.
- src1, src2 and sign are sampled only on the accepting edge. Later changes have no effect.

## Timing
- Normal op: handshake at cycle 0, BUSY cycles 1–32, out_valid first high at cycle 33.
- Divide-by-zero and signed overflow: out_valid first high at cycle 1.
- Throughput: one operation per 34 cycles minimum when out_ready is held high (33 to result + 1 IDLE cycle).
- in_ready and out_valid are registered state decodes with no combinational path from the inputs.
- Reset asserted in any state returns to the reset values immediately. The operation is lost and no out_valid is produced for it.

## Configuration
- **DIV_ABORT_EN defined:** the abort port exists.
  - abort = 1 in BUSY or DONE → IDLE on the next edge; out_valid deasserts and the operation is dropped.
  - abort has priority over out_ready in DONE.
  - abort in IDLE is ignored, and a simultaneous in_valid is still accepted.
  - quotient and remainder retain their last values.
- **DIV_ABORT_EN not defined:** no abort port. Every accepted operation runs to DONE unless reset intervenes.

## Test plan
- Unsigned 100 / 7, out_ready = 1 → out_valid at cycle 33, quotient = 14, remainder = 2, IDLE at cycle 34.
- Signed cases, each with out_valid at cycle 33:
  - -7 / 2 → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
  - 7 / -2 → quotient = 0xFFFFFFFD, remainder = 1.
  - 0xFFFFFFFF / 2 with sign = 0 → quotient = 0x7FFFFFFF, remainder = 1.
- Special cases, each with out_valid at cycle 1:
  - 5 / 0, sign = 1 → quotient = 0xFFFFFFFF, remainder = 5.
  - 0x80000000 / 0xFFFFFFFF, sign = 1 → quotient = 0x80000000, remainder = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → quotient and remainder unchanged, in_ready = 0 throughout. Toggle src1 and src2 meanwhile → no effect on the result.
- Reset mid-op: deassert resetn at BUSY cycle 15 → out_valid = 0 and in_ready = 1 immediately. After release, a fresh 9 / 3 → quotient = 3, remainder = 0 at cycle 33.
- Abort (DIV_ABORT_EN only): abort at BUSY cycle 10 → IDLE next cycle with no out_valid. Abort in DONE with out_ready = 1 → IDLE with no handshake counted.

Source files
------------

// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider.
// The abort line exists only when DIV_ABORT_EN is defined.
`timescale 1ns/1ps
interface div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ABORT_EN
    logic        abort;

    modport slave  (input  in_valid, src1, src2, sign, out_ready, abort,
                    output in_ready, out_valid, quotient, remainder);
    modport master (output in_valid, src1, src2, sign, out_ready, abort,
                    input  in_ready, out_valid, quotient, remainder);
`else
    modport slave  (input  in_valid, src1, src2, sign, out_ready,
                    output in_ready, out_valid, quotient, remainder);
    modport master (output in_valid, src1, src2, sign, out_ready,
                    input  in_ready, out_valid, quotient, remainder);
`endif
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider, 32-bit signed/unsigned, one quotient bit per cycle.
// Optional DIV_ABORT_EN adds an abort input that drops the in-flight operation.
`timescale 1ns/1ps
module div_iter (
    input  logic      clk,
    input  logic      resetn,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, r_next;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;

    logic        w_abort;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_qbit;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;

`ifdef DIV_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_div0 = (bus.src2 == 32'd0);
    assign w_ovf  = bus.sign && (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
    // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
    assign w_mag1 = (bus.sign && bus.src1[31]) ? (32'd0 - bus.src1) : bus.src1;
    assign w_mag2 = (bus.sign && bus.src2[31]) ? (32'd0 - bus.src2) : bus.src2;

    assign w_shift    = {r_rem[31:0], r_dvd[31]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_trial[32];
    assign w_rem_next = w_qbit ? w_trial : w_shift;
    assign w_quo_next = {r_quo[30:0], w_qbit};

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) r_next = (w_div0 || w_ovf) ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (w_abort)              r_next = S_IDLE;
                else if (r_cnt == 5'd31)  r_next = S_DONE;
            end
            S_DONE: if (w_abort || bus.out_ready) r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    if (w_div0) begin
                        r_quotient  <= 32'hFFFF_FFFF;
                        r_remainder <= bus.src1;
                    end else if (w_ovf) begin
                        r_quotient  <= 32'h8000_0000;
                        r_remainder <= 32'd0;
                    end else begin
                        r_dvd   <= w_mag1;
                        r_dvs   <= w_mag2;
                        r_neg_q <= bus.sign & (bus.src1[31] ^ bus.src2[31]);
                        r_neg_r <= bus.sign & bus.src1[31];
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: if (!w_abort) begin
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_quotient  <= r_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
                        r_remainder <= r_neg_r ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus random ops against a
// plain-arithmetic reference; abort cases are built only with DIV_ABORT_EN.
`timescale 1ns/1ps
module tb_div_iter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    div_iter_if bus ();
    div_iter dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: special cases first, then language arithmetic on wide ints.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; lat = 1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0]; r = lr[31:0]; lat = 33;
        end
    endtask

    // Issue one op, measure latency, optionally stall the consumer, then drain.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        logic [31:0] eq, er;
        int elat, cyc;
        model(a, b, s, eq, er, elat);
        bus.src1 = a; bus.src2 = b; bus.sign = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.src1 = ~a; bus.src2 = b ^ 32'h5A5A_0001; bus.sign = ~s;
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            chk({tag, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, elat);
        chk({tag, ".q"}, bus.quotient, eq);
        chk({tag, ".r"}, bus.remainder, er);
        for (int i = 0; i < hold; i++) begin
            bus.src1 = $urandom; bus.src2 = $urandom;
            tick();
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_q"}, bus.quotient, eq);
            chk({tag, ".hold_r"}, bus.remainder, er);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.src1 = '0; bus.src2 = '0; bus.sign = 1'b0;
`ifdef DIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        #3;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.q", bus.quotient, 32'd0);
        chk("rst.r", bus.remainder, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
        run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_op("uFF_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        run_op("div0", 32'd5, 32'd0, 1'b1, 0);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("smin_2", 32'h8000_0000, 32'd2, 1'b1, 0);
        run_op("bp", 32'd1000, 32'd33, 1'b1, 10);

        // Reset mid-operation at BUSY cycle 15.
        bus.src1 = 32'd77; bus.src2 = 32'd5; bus.sign = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        resetn = 1'b0;
        #1;
        chk("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstmid.q", bus.quotient, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        run_op("after_rst", 32'd9, 32'd3, 1'b0, 0);

`ifdef DIV_ABORT_EN
        bus.src1 = 32'd500; bus.src2 = 32'd7; bus.sign = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_busy.out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("abort_busy.no_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.src1 = 32'd5; bus.src2 = 32'd0; bus.sign = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("abort_done.valid", 32'(bus.out_valid), 32'd1);
        bus.abort = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        chk("abort_done.idle", 32'(bus.in_ready), 32'd1);
        chk("abort_done.q_kept", bus.quotient, 32'hFFFF_FFFF);
        chk("abort_done.r_kept", bus.remainder, 32'd5);
`endif

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(1, 31);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op("rand", ra, rb, rs, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
